// File: rtl/dram_port_arbiter.sv
// Two-port round-robin arbiter in front of a single DRAM controller.
// One transaction is in flight at a time: IDLE issues, BUSY waits for the
// controller, RESP hands the data back to the owner for one cycle.
module dram_port_arbiter #(
    parameter int ADDR_W  = 27,
    parameter int DATA_W  = 32,
    parameter int TMO_CYC = 4096
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] din0,
    input  logic              rw0,
    input  logic              valid0,
    output logic [DATA_W-1:0] dout0,
    output logic              ready0,

    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] din1,
    input  logic              rw1,
    input  logic              valid1,
    output logic [DATA_W-1:0] dout1,
    output logic              ready1,

    output logic [ADDR_W-1:0] addr_dram,
    output logic [DATA_W-1:0] din_dram,
    output logic              rw_dram,
    output logic              valid_dram,
    input  logic [DATA_W-1:0] dout_dram,
    input  logic              ready_dram,

    output logic [1:0]        grant,
    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_VAL = CNT_W'(TMO_CYC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_dram_q, addr_dram_d;
    logic [DATA_W-1:0]   din_dram_q, din_dram_d;
    logic                rw_dram_q, rw_dram_d;
    logic                valid_dram_q, valid_dram_d;
    logic [DATA_W-1:0]   dout0_q, dout0_d;
    logic [DATA_W-1:0]   dout1_q, dout1_d;
    logic                ready0_q, ready0_d;
    logic                ready1_q, ready1_d;
    logic [1:0]          grant_q, grant_d;
    logic                busy_q, busy_d;
    logic                timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    // 1 means port 1 was granted most recently, so port 0 wins the next tie
    logic                last_grant_q, last_grant_d;
    logic                win1;

    // Next-state and next-output computation for the whole transaction FSM
    always_comb begin
        state_d       = state_q;
        addr_dram_d   = addr_dram_q;
        din_dram_d    = din_dram_q;
        rw_dram_d     = rw_dram_q;
        valid_dram_d  = valid_dram_q;
        dout0_d       = dout0_q;
        dout1_d       = dout1_q;
        ready0_d      = ready0_q;
        ready1_d      = ready1_q;
        grant_d       = grant_q;
        timeout_err_d = timeout_err_q;
        wait_cnt_d    = wait_cnt_q;
        last_grant_d  = last_grant_q;
        win1          = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid0 || valid1) begin
                    win1         = valid1 && (!valid0 || !last_grant_q);
                    last_grant_d = win1;
                    if (win1) begin
                        addr_dram_d = addr1;
                        din_dram_d  = din1;
                        rw_dram_d   = rw1;
                        grant_d     = 2'b10;
                    end else begin
                        addr_dram_d = addr0;
                        din_dram_d  = din0;
                        rw_dram_d   = rw0;
                        grant_d     = 2'b01;
                    end
                    valid_dram_d = 1'b1;
                    wait_cnt_d   = '0;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (wait_cnt_q != TMO_VAL) begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
                if (wait_cnt_d == TMO_VAL) begin
                    timeout_err_d = 1'b1;
                end
                if (ready_dram) begin
                    valid_dram_d = 1'b0;
                    if (grant_q[1]) begin
                        dout1_d  = dout_dram;
                        ready1_d = 1'b1;
                    end else begin
                        dout0_d  = dout_dram;
                        ready0_d = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                ready0_d = 1'b0;
                ready1_d = 1'b0;
                grant_d  = 2'b00;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // All state and outputs are registered here, cleared by the async reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_dram_q   <= '0;
            din_dram_q    <= '0;
            rw_dram_q     <= 1'b0;
            valid_dram_q  <= 1'b0;
            dout0_q       <= '0;
            dout1_q       <= '0;
            ready0_q      <= 1'b0;
            ready1_q      <= 1'b0;
            grant_q       <= 2'b00;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            wait_cnt_q    <= '0;
            last_grant_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            addr_dram_q   <= addr_dram_d;
            din_dram_q    <= din_dram_d;
            rw_dram_q     <= rw_dram_d;
            valid_dram_q  <= valid_dram_d;
            dout0_q       <= dout0_d;
            dout1_q       <= dout1_d;
            ready0_q      <= ready0_d;
            ready1_q      <= ready1_d;
            grant_q       <= grant_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            wait_cnt_q    <= wait_cnt_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign addr_dram   = addr_dram_q;
    assign din_dram    = din_dram_q;
    assign rw_dram     = rw_dram_q;
    assign valid_dram  = valid_dram_q;
    assign dout0       = dout0_q;
    assign dout1       = dout1_q;
    assign ready0      = ready0_q;
    assign ready1      = ready1_q;
    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule
